rr_srdy_arbiter: RTL
====================

// Module: rr_srdy_arbiter
// PURPOSE
//  N-requester round-robin arbiter sharing one srdy/rrdy downstream channel (typically an elastic_buf).
//  Each requester presents srdy/data/rrdy; one registered output stage carries the winner's beat plus its source id.
//  Full throughput (1 beat/clk), 1-cycle latency, fair rotation after every accepted beat (or packet, see CONFIGURATION).
// PARAMETERS
//  NUM_REQ  4  number of requesters, >=2
//  DATA_W   8  data width per requester
//  ID_W     $clog2(NUM_REQ)  width of out_id (derived localparam, not overridable)
// PORTS
//  clk       in   1               single clock, all state on posedge
//  rst       in   1               synchronous, active-high reset
//  in_srdy   in   NUM_REQ         per-requester sender-ready (valid)
//  in_data   in   NUM_REQ*DATA_W  requester i data at [i*DATA_W +: DATA_W]
//  in_rrdy   out  NUM_REQ         per-requester receiver-ready; at most one bit set (one-hot or zero)
//  out_srdy  out  1               output beat valid
//  out_data  out  DATA_W          output beat data
//  out_id    out  ID_W            index of requester that produced out_data
//  out_rrdy  in   1               downstream receiver-ready
//  in_last   in   NUM_REQ         (ARB_PKT_LOCK_EN only) last beat of packet, per requester
//  out_last  out  1               (ARB_PKT_LOCK_EN only) registered copy of winner's in_last
// BEHAVIOUR
//  - Transfer on any channel = srdy & rrdy at posedge clk; sender holds srdy/data stable until transfer.
//  - Reset (rst=1 at posedge): out_srdy=0, out_data=0, out_id=0, out_last=0, ptr=0, state=IDLE.
//    in_rrdy forced to 0 while rst=1 (combinational). Reset mid-operation drops the held beat; no output.
//  - load = ~out_srdy | out_rrdy (output reg empty or draining this cycle).
//  - Winner g = first i with in_srdy[i]=1 scanning ptr, ptr+1, ... wrapping NUM_REQ-1 -> 0.
//  - in_rrdy[g] = load & ~rst; all other in_rrdy bits 0. No requester -> in_rrdy=0.
//  - in_rrdy combinationally depends on in_srdy and out_rrdy; no dependency of in_srdy on in_rrdy allowed.
//  - On transfer from g: out_data<=in_data[g], out_id<=g, out_srdy<=1; ptr<=(g+1) mod NUM_REQ.
//  - load & no transfer -> out_srdy<=0. ~load -> output reg holds (stall), ptr holds.
//  - Simultaneous drain + new transfer in one cycle: new beat replaces old, out_srdy stays 1 (no bubble).
//  - Latency: beat accepted at edge k is on out_* during cycle k+1.
//  - Fairness: continuously requesting port waits at most NUM_REQ-1 granted beats.
//  - ptr wrap: g=NUM_REQ-1 -> ptr=0. NUM_REQ not power of 2: ptr never exceeds NUM_REQ-1.
// CONFIGURATION
//  ARB_PKT_LOCK_EN defined:
//   - in_last/out_last ports present; FSM states IDLE, LOCKED; reg lock_id.
//   - IDLE: arbitration as above. Transfer from g with in_last[g]=0 -> LOCKED, lock_id<=g.
//     Transfer with in_last[g]=1 -> stay IDLE (single-beat packet).
//   - LOCKED: only lock_id eligible; in_rrdy[lock_id]=load, others 0, even if lock_id srdy=0.
//     Transfer from lock_id with in_last=1 -> IDLE. ptr<=lock_id+1 only on that last beat.
//   - out_last<=in_last[g] on each transfer.
//  ARB_PKT_LOCK_EN undefined: no in_last/out_last ports, no FSM; arbitration every beat.
// TESTING
//  T1 reset: rst=1 2 clks, all in_srdy=1 -> in_rrdy=0, out_srdy=0; release -> port0 granted first.
//  T2 rotation: all 4 srdy=1, data=8'h10..8'h13, out_rrdy=1 -> out_id 0,1,2,3,0... one per clk, no gaps.
//  T3 stall: out_srdy=1 id=2 data=8'h12, out_rrdy=0 3 clks -> out stable, in_rrdy=0, ptr held; release -> next id=3.
//  T4 sparse/wrap: only port3 then port1 request, ptr=2 -> grant 3 then 1; ptr 0 then 2.
//  T5 reset mid-op: rst asserted with out_srdy=1 data=8'hFF -> next clk out_srdy=0, beat discarded.
//  T6 (ARB_PKT_LOCK_EN) port1 3-beat pkt (last on beat 3), port2 srdy=1 throughout -> port2 granted only after beat 3.

Source files
------------

// File: rtl/rr_srdy_arbiter.sv
// ============================================================================
// rr_srdy_arbiter
// ----------------------------------------------------------------------------
// Round-robin arbiter that merges NUM_REQ srdy/rrdy (valid/ready) requester
// channels onto one downstream srdy/rrdy channel. A single registered output
// stage carries the winning beat together with the index of its source.
// It sustains one beat per clock with one cycle of latency. The arbiter
// rotates priority after every accepted beat. With packet locking enabled,
// it rotates after every accepted packet instead.
//
// Optional feature (compile-time macro):
//   ARB_PKT_LOCK_EN  - packet locking. It adds the in_last/out_last ports.
//                      A requester that wins the first beat of a multi-beat
//                      packet keeps the channel until it transfers the beat
//                      marked last.
//
// Ports:
//   clk       in   1               clock; all state updates on posedge
//   rst       in   1               synchronous active-high reset
//   in_srdy   in   NUM_REQ         per-requester beat valid
//   in_data   in   NUM_REQ*DATA_W  requester i data at [i*DATA_W +: DATA_W]
//   in_last   in   NUM_REQ         (ARB_PKT_LOCK_EN) last beat of packet
//   in_rrdy   out  NUM_REQ         per-requester ready; one-hot or zero
//   out_srdy  out  1               output beat valid
//   out_data  out  DATA_W          output beat data
//   out_id    out  ID_W            index of the requester that sent out_data
//   out_last  out  1               (ARB_PKT_LOCK_EN) winner's in_last
//   out_rrdy  in   1               downstream ready
// ============================================================================
module rr_srdy_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 8,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        in_srdy,
    input  logic [NUM_REQ*DATA_W-1:0] in_data,
`ifdef ARB_PKT_LOCK_EN
    input  logic [NUM_REQ-1:0]        in_last,
`endif
    output logic [NUM_REQ-1:0]        in_rrdy,
    output logic                      out_srdy,
    output logic [DATA_W-1:0]         out_data,
    output logic [ID_W-1:0]           out_id,
`ifdef ARB_PKT_LOCK_EN
    output logic                      out_last,
`endif
    input  logic                      out_rrdy
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              out_srdy_q, out_srdy_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ID_W-1:0]   out_id_q,   out_id_d;
    logic [ID_W-1:0]   ptr_q,      ptr_d;

`ifdef ARB_PKT_LOCK_EN
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t            state_q,    state_d;
    logic [ID_W-1:0]   lock_id_q,  lock_id_d;
    logic              out_last_q, out_last_d;
`endif

    // ------------------------------------------------------------------
    // Unpack the flat data bus into one word per requester
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] data_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign data_arr[gi] = in_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin search.
    // The loop runs from the farthest offset down to offset 0. Each hit
    // overwrites the previous one, so the result is the requester
    // closest to ptr in the wrap-around scan order.
    // ------------------------------------------------------------------
    logic            rr_found;
    logic [ID_W-1:0] rr_idx;
    logic [ID_W:0]   scan_pos;
    logic [ID_W-1:0] scan_idx;

    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        scan_pos = '0;
        scan_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            // ptr_q < NUM_REQ and k < NUM_REQ, so a single subtraction
            // is enough to wrap the sum back into range.
            scan_pos = {1'b0, ptr_q} + (ID_W + 1)'(k);
            if (scan_pos >= (ID_W + 1)'(NUM_REQ)) begin
                scan_pos = scan_pos - (ID_W + 1)'(NUM_REQ);
            end
            scan_idx = scan_pos[ID_W-1:0];
            if (in_srdy[scan_idx]) begin
                rr_found = 1'b1;
                rr_idx   = scan_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Grant selection and handshake
    // ------------------------------------------------------------------
    logic            sel_valid;
    logic [ID_W-1:0] sel_idx;
    logic [ID_W-1:0] sel_next;
    logic            load;
    logic            xfer;

    always_comb begin
        sel_valid = rr_found;
        sel_idx   = rr_idx;
`ifdef ARB_PKT_LOCK_EN
        // While a packet is open, only its owner may be offered the channel.
        // The owner is offered the channel even when it has no beat ready.
        if (state_q == ST_LOCKED) begin
            sel_valid = 1'b1;
            sel_idx   = lock_id_q;
        end
`endif
    end

    // The output register can take a new beat when it is empty or when it
    // is being drained in this same cycle.
    assign load = ~out_srdy_q | out_rrdy;

    always_comb begin
        in_rrdy = '0;
        if (sel_valid && load && !rst) begin
            in_rrdy[sel_idx] = 1'b1;
        end
    end

    assign xfer = sel_valid & load & ~rst & in_srdy[sel_idx];

    // Priority moves to the requester just after the winner.
    assign sel_next = (sel_idx == ID_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        out_srdy_d = out_srdy_q;
        out_data_d = out_data_q;
        out_id_d   = out_id_q;
        ptr_d      = ptr_q;
`ifdef ARB_PKT_LOCK_EN
        state_d    = state_q;
        lock_id_d  = lock_id_q;
        out_last_d = out_last_q;
`endif

        // When load is low, the output register and the pointer both hold.
        // When load is high, the register is refilled or goes empty.
        if (load) begin
            out_srdy_d = xfer;
            if (xfer) begin
                out_data_d = data_arr[sel_idx];
                out_id_d   = sel_idx;
`ifdef ARB_PKT_LOCK_EN
                out_last_d = in_last[sel_idx];
                if (in_last[sel_idx]) begin
                    // End of packet: release any lock and rotate priority.
                    state_d = ST_IDLE;
                    ptr_d   = sel_next;
                end else begin
                    // Packet continues: pin the channel to this requester.
                    // The pointer stays put until the last beat.
                    state_d   = ST_LOCKED;
                    lock_id_d = sel_idx;
                end
`else
                ptr_d = sel_next;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // A beat held in the output register is dropped.
            out_srdy_q <= 1'b0;
            out_data_q <= '0;
            out_id_q   <= '0;
            ptr_q      <= '0;
`ifdef ARB_PKT_LOCK_EN
            state_q    <= ST_IDLE;
            lock_id_q  <= '0;
            out_last_q <= 1'b0;
`endif
        end else begin
            out_srdy_q <= out_srdy_d;
            out_data_q <= out_data_d;
            out_id_q   <= out_id_d;
            ptr_q      <= ptr_d;
`ifdef ARB_PKT_LOCK_EN
            state_q    <= state_d;
            lock_id_q  <= lock_id_d;
            out_last_q <= out_last_d;
`endif
        end
    end

    assign out_srdy = out_srdy_q;
    assign out_data = out_data_q;
    assign out_id   = out_id_q;
`ifdef ARB_PKT_LOCK_EN
    assign out_last = out_last_q;
`endif

endmodule
